// File: rtl/call_return_unit.sv
// -----------------------------------------------------------------------------
// call_return_unit
//
// Purpose:
//   Sequences CALL / RET requests from decode against an external LIFO
//   (the hardware return stack) and hands the resulting next PC to fetch.
//   - CALL pushes the return address (pc+1) and redirects to call_target.
//   - RET pops the return address and redirects to it.
//   - Overflow and underflow are detected before the stack is touched. The
//     request is then redirected without any stack access, and a sticky
//     error flag is set.
//
// Configuration:
//   CALL_RETURN_TRAP_EN -- when defined, a stack fault redirects to
//   TRAP_VECTOR. When undefined (default), an overflowed CALL still goes to
//   call_target (its push is dropped), and an underflowed RET falls through
//   to pc+1.
//
// Parameters:
//   PC_WIDTH    width of PC values and of the stack data word
//   DEPTH       return-stack capacity in entries (must fit in 6 bits)
//   TRAP_VECTOR redirect address on a stack fault (trap build only)
//
// Ports:
//   clock, reset               rising-edge clock, async active-high reset
//   req_valid / req_ready      decode request handshake (ready only in IDLE)
//   is_call, is_ret            request kind
//   pc, call_target            requesting PC and CALL destination
//   resp_valid / resp_ready    next-PC response handshake to fetch
//   resp_pc                    next PC, held stable while resp_valid=1
//   stack_push, stack_pop      one-cycle strobes to the LIFO
//   stack_din                  return address being pushed
//   stack_dout                 LIFO pop data, valid the cycle after the pop edge
//   stack_full, stack_empty    LIFO status flags
//   depth                      entries currently held, 0..DEPTH
//   err_overflow/underflow     sticky fault flags, cleared only by reset
// -----------------------------------------------------------------------------
module call_return_unit #(
  parameter int unsigned          PC_WIDTH    = 32,
  parameter int unsigned          DEPTH       = 32,
  parameter logic [PC_WIDTH-1:0]  TRAP_VECTOR = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                is_call,
  input  logic                is_ret,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [PC_WIDTH-1:0] call_target,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [PC_WIDTH-1:0] resp_pc,
  output logic                stack_push,
  output logic                stack_pop,
  output logic [PC_WIDTH-1:0] stack_din,
  input  logic [PC_WIDTH-1:0] stack_dout,
  input  logic                stack_full,
  input  logic                stack_empty,
  output logic [5:0]          depth,
  output logic                err_overflow,
  output logic                err_underflow
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PUSH    = 3'd1,
    POP     = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  localparam logic [5:0]          DEPTH_MAX = 6'(DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_ONE    = {{(PC_WIDTH-1){1'b0}}, 1'b1};

`ifdef CALL_RETURN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] r_target;
  logic                r_fault_call;   // 1: fault came from a CALL, 0: from a RET
  logic                r_req_ready;
  logic                r_resp_valid;
  logic [PC_WIDTH-1:0] r_resp_pc;
  logic                r_stack_push;
  logic                r_stack_pop;
  logic [PC_WIDTH-1:0] r_stack_din;
  logic [5:0]          r_depth;
  logic                r_err_overflow;
  logic                r_err_underflow;

  logic                w_call_only;
  logic                w_ret_only;
  logic                w_full;
  logic                w_empty;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_fault_pc;

  // Request decode. The block's own depth count is checked alongside the
  // LIFO flags, so a flag that disagrees with the count still faults safely.
  assign w_call_only = is_call & ~is_ret;
  assign w_ret_only  = is_ret & ~is_call;
  assign w_full      = stack_full | (r_depth == DEPTH_MAX);
  assign w_empty     = stack_empty | (r_depth == 6'd0);
  assign w_pc_inc    = pc + PC_ONE;
  assign w_fault_pc  = TRAP_EN ? TRAP_VECTOR
                     : (r_fault_call ? r_target : (r_pc + PC_ONE));

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_pc            <= '0;
      r_target        <= '0;
      r_fault_call    <= 1'b0;
      r_req_ready     <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_resp_pc       <= '0;
      r_stack_push    <= 1'b0;
      r_stack_pop     <= 1'b0;
      r_stack_din     <= '0;
      r_depth         <= 6'd0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_pc        <= pc;
            r_target    <= call_target;
            r_req_ready <= 1'b0;
            if (w_call_only) begin
              if (w_full) begin
                r_err_overflow <= 1'b1;
                r_fault_call   <= 1'b1;
                r_state        <= FAULT;
              end else begin
                r_stack_push <= 1'b1;
                r_stack_din  <= w_pc_inc;
                r_state      <= PUSH;
              end
            end else if (w_ret_only) begin
              if (w_empty) begin
                r_err_underflow <= 1'b1;
                r_fault_call    <= 1'b0;
                r_state         <= FAULT;
              end else begin
                r_stack_pop <= 1'b1;
                r_state     <= POP;
              end
            end else begin
              // Ambiguous or empty request: fall through without stack access.
              r_resp_pc    <= w_pc_inc;
              r_resp_valid <= 1'b1;
              r_state      <= RESP;
            end
          end else begin
            r_state <= IDLE;
          end
        end

        PUSH: begin
          r_stack_push <= 1'b0;
          r_stack_din  <= '0;
          if (r_depth != DEPTH_MAX) begin
            r_depth <= r_depth + 6'd1;
          end else begin
            r_depth <= r_depth;
          end
          r_resp_pc    <= r_target;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end

        POP: begin
          r_stack_pop <= 1'b0;
          if (r_depth != 6'd0) begin
            r_depth <= r_depth - 6'd1;
          end else begin
            r_depth <= r_depth;
          end
          r_state <= CAPTURE;
        end

        CAPTURE: begin
          // The LIFO presents pop data one cycle after the pop edge.
          r_resp_pc    <= stack_dout;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end

        FAULT: begin
          r_resp_pc    <= w_fault_pc;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end

        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= IDLE;
          end else begin
            r_state <= RESP;
          end
        end

        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_stack_push <= 1'b0;
          r_stack_pop  <= 1'b0;
          r_stack_din  <= '0;
        end
      endcase
    end
  end

  assign req_ready     = r_req_ready;
  assign resp_valid    = r_resp_valid;
  assign resp_pc       = r_resp_pc;
  assign stack_push    = r_stack_push;
  assign stack_pop     = r_stack_pop;
  assign stack_din     = r_stack_din;
  assign depth         = r_depth;
  assign err_overflow  = r_err_overflow;
  assign err_underflow = r_err_underflow;

endmodule

// File: tb/tb_call_return_unit.sv
// -----------------------------------------------------------------------------
// tb_call_return_unit
//
// Directed, self-checking bench for call_return_unit with default parameters.
// A behavioural LIFO drives stack_dout/full/empty. Expected next-PC values are
// queued when a request is driven, and they are popped when resp_valid is seen.
// -----------------------------------------------------------------------------
module tb_call_return_unit;

  localparam logic [31:0] TRAP_PC = 32'h0000_0000;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        is_call;
  logic        is_ret;
  logic [31:0] pc;
  logic [31:0] call_target;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_pc;
  logic        stack_push;
  logic        stack_pop;
  logic [31:0] stack_din;
  logic [31:0] stack_dout;
  logic        stack_full;
  logic        stack_empty;
  logic [5:0]  depth;
  logic        err_overflow;
  logic        err_underflow;

  int          n_checks;
  int          n_fail;
  logic [31:0] exp_q[$];

  call_return_unit dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .is_call      (is_call),
    .is_ret       (is_ret),
    .pc           (pc),
    .call_target  (call_target),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_pc      (resp_pc),
    .stack_push   (stack_push),
    .stack_pop    (stack_pop),
    .stack_din    (stack_din),
    .stack_dout   (stack_dout),
    .stack_full   (stack_full),
    .stack_empty  (stack_empty),
    .depth        (depth),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural 32-entry LIFO; pop data appears the cycle after the pop edge.
  logic [31:0] mem [0:63];
  int          cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= 0;
      stack_dout <= 32'h0;
    end else if (stack_push && cnt < 64) begin
      mem[cnt] <= stack_din;
      cnt      <= cnt + 1;
    end else if (stack_pop && cnt > 0) begin
      stack_dout <= mem[cnt-1];
      cnt        <= cnt - 1;
    end
  end
  assign stack_full  = (cnt >= 32);
  assign stack_empty = (cnt == 0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request through to response; entered and left at posedge+1.
  task automatic do_req(input logic c, input logic r, input logic [31:0] p,
                        input logic [31:0] t, input logic [31:0] exp_pc,
                        input int exp_lat, input int exp_push, input int exp_pop,
                        input logic [31:0] exp_din, input int hold);
    int          lat;
    int          npush;
    int          npop;
    logic [31:0] got_din;
    logic [31:0] e;
    check("req_ready_idle", req_ready, 1);
    is_call = c; is_ret = r; pc = p; call_target = t; req_valid = 1'b1;
    exp_q.push_back(exp_pc);
    @(posedge clock); #1;
    req_valid = 1'b0; is_call = 1'b0; is_ret = 1'b0;
    lat = 1; npush = 0; npop = 0; got_din = 32'h0;
    while (!resp_valid && lat < 10) begin
      check("push_pop_excl", stack_push & stack_pop, 0);
      if (stack_push) begin
        npush++;
        got_din = stack_din;
      end
      if (stack_pop) npop++;
      @(posedge clock); #1;
      lat++;
    end
    check("resp_latency", lat, exp_lat);
    check("resp_valid", resp_valid, 1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    check("resp_pc", resp_pc, e);
    check("push_count", npush, exp_push);
    check("pop_count", npop, exp_pop);
    if (exp_push > 0) check("stack_din", got_din, exp_din);
    for (int k = 0; k < hold; k++) begin
      @(posedge clock); #1;
      check("hold_valid", resp_valid, 1);
      check("hold_resp_pc", resp_pc, e);
      check("hold_req_ready", req_ready, 0);
      check("hold_no_stack", {stack_push, stack_pop}, 0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    check("resp_done_valid", resp_valid, 0);
    check("resp_done_ready", req_ready, 1);
  endtask

  logic [31:0] fault_ret_pc;
  logic [31:0] fault_call_pc;

  initial begin
    n_checks = 0; n_fail = 0;
    reset = 1'b1; req_valid = 1'b0; is_call = 1'b0; is_ret = 1'b0;
    pc = 32'h0; call_target = 32'h0; resp_ready = 1'b0;
`ifdef CALL_RETURN_TRAP_EN
    fault_ret_pc  = TRAP_PC;
    fault_call_pc = TRAP_PC;
`else
    fault_ret_pc  = 32'h0000_0091;
    fault_call_pc = 32'h0000_0280;
`endif

    // Reset state
    @(posedge clock); @(posedge clock); #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_pc", resp_pc, 0);
    check("rst_strobes", {stack_push, stack_pop}, 0);
    check("rst_stack_din", stack_din, 0);
    check("rst_depth", depth, 0);
    check("rst_errs", {err_overflow, err_underflow}, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // CALL pc=0x10 -> 0x80, push 0x11
    do_req(1'b1, 1'b0, 32'h10, 32'h80, 32'h80, 2, 1, 0, 32'h11, 0);
    check("call_depth", depth, 1);
    // RET -> 0x11
    do_req(1'b0, 1'b1, 32'h84, 32'h0, 32'h11, 3, 0, 1, 32'h0, 0);
    check("ret_depth", depth, 0);
    // RET on empty stack
    do_req(1'b0, 1'b1, 32'h90, 32'h0, fault_ret_pc, 2, 0, 0, 32'h0, 0);
    check("underflow_flag", err_underflow, 1);
    check("underflow_depth", depth, 0);
    check("underflow_no_ovf", err_overflow, 0);
    // Neither / both: fall through, no stack access
    do_req(1'b0, 1'b0, 32'h40, 32'h99, 32'h41, 1, 0, 0, 32'h0, 0);
    do_req(1'b1, 1'b1, 32'h50, 32'h99, 32'h51, 1, 0, 0, 32'h0, 0);
    check("nop_depth", depth, 0);

    // 32 CALLs, the first held in RESP for 5 cycles
    for (int i = 0; i < 32; i++) begin
      do_req(1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i),
             32'h2000 + 32'(i), 2, 1, 0, 32'h1001 + 32'(i * 4), (i == 0) ? 5 : 0);
    end
    check("full_depth", depth, 32);
    check("full_no_ovf", err_overflow, 0);
    check("model_full", stack_full, 1);
    // 33rd CALL overflows
    do_req(1'b1, 1'b0, 32'h200, 32'h280, fault_call_pc, 2, 0, 0, 32'h0, 0);
    check("overflow_flag", err_overflow, 1);
    check("overflow_depth", depth, 32);
    // RET from full returns last pushed address
    do_req(1'b0, 1'b1, 32'h3000, 32'h0, 32'h1001 + 32'(31 * 4), 3, 0, 1, 32'h0, 0);
    check("pop_full_depth", depth, 31);
    check("sticky_underflow", err_underflow, 1);
    check("sticky_overflow", err_overflow, 1);

    // Reset during POP abandons the RET
    check("pre_rst_ready", req_ready, 1);
    is_ret = 1'b1; pc = 32'h500; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0; is_ret = 1'b0;
    check("in_pop_strobe", stack_pop, 1);
    #2 reset = 1'b1;
    #1;
    check("async_pop_drop", stack_pop, 0);
    check("async_depth", depth, 0);
    check("async_req_ready", req_ready, 1);
    check("async_errs", {err_overflow, err_underflow}, 0);
    #2 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clock); #1;
      check("no_resp_after_rst", {resp_valid, stack_pop, stack_push}, 0);
    end
    check("model_empty", stack_empty, 1);
    // Operation resumes from depth 0
    do_req(1'b1, 1'b0, 32'h600, 32'h700, 32'h700, 2, 1, 0, 32'h601, 0);
    check("resume_depth", depth, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/call_return_unit.md
CALL_RETURN_UNIT -- requirements
Module: call_return_unit

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 32, the width of program-counter values and of the stack data word.
REQ-002 The block SHALL have parameter DEPTH, default 32, the return-stack capacity in entries.
REQ-003 The block SHALL have parameter TRAP_VECTOR, default 32'h0000_0000, the redirect address on a stack fault.
REQ-004 The block SHALL have these ports:
- clock  in  1  single clock, all state rising-edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  decode presents a CALL or RET.
- req_ready  out  1  block can accept a request.
- is_call  in  1  request is CALL.
- is_ret  in  1  request is RET.
- pc  in  PC_WIDTH  address of the requesting instruction.
- call_target  in  PC_WIDTH  CALL destination.
- resp_valid  out  1  next-PC response available.
- resp_ready  in  1  fetch accepts the response.
- resp_pc  out  PC_WIDTH  next PC.
- stack_push  out  1  push strobe to the LIFO.
- stack_pop  out  1  pop strobe to the LIFO.
- stack_din  out  PC_WIDTH  return address to push.
- stack_dout  in  PC_WIDTH  LIFO pop data, valid the cycle after the pop edge.
- stack_full  in  1  LIFO full flag.
- stack_empty  in  1  LIFO empty flag.
- depth  out  6  entries currently held, 0..DEPTH.
- err_overflow  out  1  sticky: a CALL found the stack full.
- err_underflow  out  1  sticky: a RET found the stack empty.

Function
REQ-005 The FSM SHALL have states IDLE, PUSH, POP, CAPTURE, RESP, FAULT; req_ready SHALL be 1 only in IDLE.
REQ-006 In IDLE, when req_valid=1, the block SHALL latch pc and call_target and leave IDLE at that edge; when req_valid=0 it SHALL remain in IDLE.
REQ-007 When is_call=1 and is_ret=0, and (stack_full=1 or depth==DEPTH), the block SHALL set err_overflow and go to FAULT; otherwise it SHALL go to PUSH.
REQ-008 When is_ret=1 and is_call=0, and (stack_empty=1 or depth==0), the block SHALL set err_underflow and go to FAULT; otherwise it SHALL go to POP.
REQ-009 When is_call and is_ret are both 1, or both 0, the block SHALL go to RESP with resp_pc=pc+1 and make no stack access.
REQ-010 In PUSH, the block SHALL assert stack_push for exactly one cycle with stack_din=latched pc+1 (modulo 2^PC_WIDTH), increment depth, and go to RESP with resp_pc=latched call_target.
REQ-011 In POP, the block SHALL assert stack_pop for exactly one cycle, decrement depth, and go to CAPTURE.
REQ-012 In CAPTURE, the block SHALL register stack_dout into resp_pc and go to RESP.
REQ-013 In RESP, resp_valid SHALL be 1 and resp_pc SHALL remain stable until resp_ready=1; at that edge the block SHALL return to IDLE.
REQ-014 Latency from the accept edge to resp_valid=1 SHALL be 2 cycles for CALL, 3 cycles for RET, and 2 cycles for FAULT.
REQ-015 stack_push and stack_pop SHALL never be asserted together, and SHALL never be asserted outside PUSH or POP.
REQ-016 depth SHALL saturate at 0 and DEPTH; it SHALL never wrap.
REQ-017 err_overflow and err_underflow SHALL be sticky until reset.

Reset
REQ-018 While reset=1, the block SHALL immediately force state IDLE, depth=0, err_overflow=0, err_underflow=0, resp_pc=0, and resp_valid, stack_push, stack_pop and stack_din all 0.
REQ-019 A reset during PUSH, POP, CAPTURE or RESP SHALL abandon the transaction; no response SHALL follow, and depth=0 SHALL be treated as the authoritative stack depth.

Configuration
REQ-020 With macro CALL_RETURN_TRAP_EN defined, FAULT SHALL go to RESP with resp_pc=TRAP_VECTOR.
REQ-021 Without CALL_RETURN_TRAP_EN, FAULT SHALL go to RESP with resp_pc=call_target for an overflowed CALL (push dropped), and resp_pc=pc+1 for an underflowed RET.

Verification
REQ-022 The bench SHALL cover: CALL pc=0x10, target=0x80 -> stack_push one cycle with stack_din=0x11, resp_valid 2 cycles after accept with resp_pc=0x80, depth=1.
REQ-023 The bench SHALL cover: after that CALL, RET with stack_dout model returning 0x11 -> stack_pop one cycle, resp_pc=0x11 3 cycles after accept, depth=0.
REQ-024 The bench SHALL cover: RET at depth=0 -> no stack_pop, err_underflow=1, resp_pc=TRAP_VECTOR with the macro, or pc+1 without it.
REQ-025 The bench SHALL cover: 32 CALLs then a 33rd CALL at pc=0x200 -> no push, err_overflow=1, depth stays 32.
REQ-026 The bench SHALL cover: resp_ready held 0 for 5 cycles in RESP -> resp_pc stable and req_ready=0 throughout.
REQ-027 The bench SHALL cover: reset asserted in POP -> stack_pop drops asynchronously, state IDLE, depth=0, and no resp_valid afterwards.
